// File: rtl/slice_pkg.sv
// -----------------------------------------------------------------------------
// slice_pkg
// Shared definitions for the slice packer: default geometry, a constant-safe
// clog2 helper, and a packed word/count record that consumers of the packed
// stream can use to carry a word together with its valid-slice count.
// -----------------------------------------------------------------------------
package slice_pkg;

  localparam int SLICE_W_DEF  = 3;
  localparam int N_SLICES_DEF = 4;

  // Ceiling log2, usable in parameter expressions. clog2(1) == 0.
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result++;
      rem = rem >> 1;
    end
    return result;
  endfunction

  localparam int WORD_W_DEF  = SLICE_W_DEF * N_SLICES_DEF;
  localparam int COUNT_W_DEF = clog2(N_SLICES_DEF + 1);

  // One packed output word and the number of slices it actually carries.
  typedef struct packed {
    logic [COUNT_W_DEF-1:0] count;
    logic [WORD_W_DEF-1:0]  data;
  } word_t;

endpackage : slice_pkg

// File: rtl/slice_packer_if.sv
// -----------------------------------------------------------------------------
// slice_packer_if
// Bundles the slice input stream and the packed-word output stream of
// slice_packer.
//   master : the environment (drives slices in, accepts words out)
//   slave  : the packer itself
// Signals:
//   in_valid/in_ready/in_data/in_last       slice stream into the packer
//   out_valid/out_ready/out_data/out_count/out_last  word stream out
// -----------------------------------------------------------------------------
interface slice_packer_if
  import slice_pkg::*;
#(
  parameter int SLICE_W  = SLICE_W_DEF,
  parameter int N_SLICES = N_SLICES_DEF
);

  localparam int WORD_W  = SLICE_W * N_SLICES;
  localparam int COUNT_W = clog2(N_SLICES + 1);

  logic               in_valid;
  logic               in_ready;
  logic [SLICE_W-1:0] in_data;
  logic               in_last;

  logic               out_valid;
  logic               out_ready;
  logic [WORD_W-1:0]  out_data;
  logic [COUNT_W-1:0] out_count;
  logic               out_last;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_count, out_last
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_count, out_last
  );

endinterface : slice_packer_if

// File: rtl/slice_accumulator.sv
// -----------------------------------------------------------------------------
// slice_accumulator
// Holds the partially assembled word and the index of the next slice slot.
// Presents, combinationally, the word as it would look with the current input
// slice merged in, the resulting slice count, and whether this beat closes the
// word. State advances only on an accepted beat.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   beat_i       an input slice is accepted this cycle
//   data_i       slice payload
//   last_i       slice closes the word early
//   word_o       accumulator merged with data_i at the current index
//   count_o      number of slices in word_o (idx + 1)
//   complete_o   this beat finishes a word (full or closed by last_i)
// -----------------------------------------------------------------------------
module slice_accumulator
  import slice_pkg::*;
#(
  parameter int SLICE_W  = SLICE_W_DEF,
  parameter int N_SLICES = N_SLICES_DEF
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 beat_i,
  input  logic [SLICE_W-1:0]                   data_i,
  input  logic                                 last_i,
  output logic [SLICE_W*N_SLICES-1:0]          word_o,
  output logic [clog2(N_SLICES+1)-1:0]         count_o,
  output logic                                 complete_o
);

  localparam int WORD_W  = SLICE_W * N_SLICES;
  localparam int COUNT_W = clog2(N_SLICES + 1);
  localparam int IDX_W   = clog2(N_SLICES);

  logic [WORD_W-1:0] acc_q, acc_d;
  logic [IDX_W-1:0]  idx_q, idx_d;

  // Slots at and above idx_q are always zero in acc_q, so overwriting the
  // current slot yields the merged word with zero-filled upper slices.
  always_comb begin
    // NOTE: every signal written in always_comb gets a default first so no
    // path leaves it unassigned and infers a latch.
    word_o = acc_q;
    for (int k = 0; k < N_SLICES; k++) begin
      if (idx_q == IDX_W'(k)) begin
        word_o[k*SLICE_W +: SLICE_W] = data_i;
      end
    end
  end

  assign complete_o = last_i || (idx_q == IDX_W'(N_SLICES - 1));
  assign count_o    = COUNT_W'(idx_q) + COUNT_W'(1);

  always_comb begin
    acc_d = acc_q;
    idx_d = idx_q;
    if (beat_i) begin
      if (complete_o) begin
        acc_d = '0;
        idx_d = '0;
      end else begin
        acc_d = word_o;
        idx_d = idx_q + IDX_W'(1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      idx_q <= '0;
    end else begin
      acc_q <= acc_d;
      idx_q <= idx_d;
    end
  end

endmodule : slice_accumulator

// File: rtl/slice_packer.sv
// -----------------------------------------------------------------------------
// slice_packer
// Packs a stream of SLICE_W-bit slices LSB-first into WORD_W-bit words. A word
// closes after N_SLICES slices or early on in_last, and appears on a registered
// output one cycle after its closing slice is accepted, with the count of
// valid slices and a flag saying whether in_last closed it.
// Ports:
//   clk     single clock
//   rst     synchronous active-high reset
//   bus_if  slice_packer_if.slave: slice input stream and word output stream
// -----------------------------------------------------------------------------
module slice_packer
  import slice_pkg::*;
#(
  parameter int SLICE_W  = SLICE_W_DEF,
  parameter int N_SLICES = N_SLICES_DEF
) (
  input  logic           clk,
  input  logic           rst,
  slice_packer_if.slave  bus_if
);

  localparam int WORD_W  = SLICE_W * N_SLICES;
  localparam int COUNT_W = clog2(N_SLICES + 1);

  if (N_SLICES < 2) begin : g_bad_n_slices
    $error("slice_packer: N_SLICES must be at least 2");
  end

  logic               accept;
  logic [WORD_W-1:0]  merged_word;
  logic [COUNT_W-1:0] merged_count;
  logic               word_done;

  logic               out_valid_q, out_valid_d;
  logic [WORD_W-1:0]  out_data_q,  out_data_d;
  logic [COUNT_W-1:0] out_count_q, out_count_d;
  logic               out_last_q,  out_last_d;

  // A slice may enter whenever the output register is empty or being drained
  // this cycle; this applies to every beat, completing or not.
  assign bus_if.in_ready = !out_valid_q || bus_if.out_ready;
  assign accept          = bus_if.in_valid && bus_if.in_ready;

  slice_accumulator #(
    .SLICE_W  (SLICE_W),
    .N_SLICES (N_SLICES)
  ) u_acc (
    .clk        (clk),
    .rst        (rst),
    .beat_i     (accept),
    .data_i     (bus_if.in_data),
    .last_i     (bus_if.in_last),
    .word_o     (merged_word),
    .count_o    (merged_count),
    .complete_o (word_done)
  );

  // A completing beat reloads the output register even if the current word is
  // being accepted in the same cycle, so out_valid stays high across handoff.
  // Payload fields hold after a drain.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_count_d = out_count_q;
    out_last_d  = out_last_q;
    if (accept && word_done) begin
      out_valid_d = 1'b1;
      out_data_d  = merged_word;
      out_count_d = merged_count;
      out_last_d  = bus_if.in_last;
    end else if (out_valid_q && bus_if.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_count_q <= '0;
      out_last_q  <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_count_q <= out_count_d;
      out_last_q  <= out_last_d;
    end
  end

  assign bus_if.out_valid = out_valid_q;
  assign bus_if.out_data  = out_data_q;
  assign bus_if.out_count = out_count_q;
  assign bus_if.out_last  = out_last_q;

endmodule : slice_packer

// File: tb/tb_slice_packer.sv
// -----------------------------------------------------------------------------
// tb_slice_packer
// Directed bench for slice_packer (SLICE_W=3, N_SLICES=4). Inputs are driven
// 1 time unit after the rising edge; outputs are compared after that drive
// settles, well away from the next edge. Output state is compared as one
// tuple {out_valid, out_count, out_last, out_data}.
// -----------------------------------------------------------------------------
module tb_slice_packer;
  import slice_pkg::*;

  localparam int SW = 3;
  localparam int NS = 4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  slice_packer_if #(.SLICE_W(SW), .N_SLICES(NS)) bus ();

  slice_packer #(.SLICE_W(SW), .N_SLICES(NS)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_if (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // {valid, count, last, data}
  function automatic logic [16:0] pack_exp(input logic v, input word_t w, input logic l);
    return {v, w.count, l, w.data};
  endfunction

  function automatic logic [16:0] observed();
    return {bus.out_valid, bus.out_count, bus.out_last, bus.out_data};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [SW-1:0] d, input logic l);
    bus.in_valid = v;
    bus.in_data  = d;
    bus.in_last  = l;
    #1;
  endtask

  task automatic send(input logic [SW-1:0] d, input logic l);
    drive(1'b1, d, l);
    tick();
  endtask

  task automatic test_reset();
    logic [16:0] exp_t;
    rst           = 1'b1;
    bus.out_ready = 1'b0;
    drive(1'b0, '0, 1'b0);
    tick();
    tick();
    exp_t = '0;
    n_checks++;
    if (observed() !== exp_t) begin
      n_fail++;
      $display("FAIL reset_state: got %h, want %h", observed(), exp_t);
    end
    rst = 1'b0;
  endtask

  task automatic test_full_word();
    word_t w;
    logic [16:0] exp_t;
    bus.out_ready = 1'b1;
    for (int i = 0; i < NS; i++) begin
      drive(1'b1, SW'(i + 1), 1'b0);
      n_checks++;
      if (bus.in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL full_in_ready beat %0d: got %b, want 1", i, bus.in_ready);
      end
      tick();
      if (i < NS - 1) begin
        n_checks++;
        if (bus.out_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL full_early_valid beat %0d: got %b, want 0", i, bus.out_valid);
        end
      end
    end
    // 1 | 2<<3 | 3<<6 | 4<<9
    w.data = 12'h8D1; w.count = 3'd4;
    exp_t = pack_exp(1'b1, w, 1'b0);
    n_checks++;
    if (observed() !== exp_t) begin
      n_fail++;
      $display("FAIL full_word: got %h, want %h", observed(), exp_t);
    end
    drive(1'b0, '0, 1'b0);
    tick();
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL full_drain: got %b, want 0", bus.out_valid);
    end
  endtask

  task automatic test_partial_and_single();
    word_t w;
    logic [16:0] exp_t;
    bus.out_ready = 1'b1;
    send(3'd5, 1'b0);
    send(3'd6, 1'b1);
    // 5 | 6<<3
    w.data = 12'h035; w.count = 3'd2;
    exp_t = pack_exp(1'b1, w, 1'b1);
    n_checks++;
    if (observed() !== exp_t) begin
      n_fail++;
      $display("FAIL partial_word: got %h, want %h", observed(), exp_t);
    end
    // Next word must restart at slot 0; it completes while 0x035 drains.
    send(3'd7, 1'b1);
    w.data = 12'h007; w.count = 3'd1;
    exp_t = pack_exp(1'b1, w, 1'b1);
    n_checks++;
    if (observed() !== exp_t) begin
      n_fail++;
      $display("FAIL single_word: got %h, want %h", observed(), exp_t);
    end
    drive(1'b0, '0, 1'b0);
    tick();
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_drain: got %b, want 0", bus.out_valid);
    end
  endtask

  task automatic test_backpressure();
    word_t w;
    logic [16:0] exp_t;
    bus.out_ready = 1'b0;
    send(3'd1, 1'b0);
    send(3'd2, 1'b0);
    send(3'd3, 1'b0);
    send(3'd4, 1'b0);
    w.data = 12'h8D1; w.count = 3'd4;
    exp_t = pack_exp(1'b1, w, 1'b0);
    drive(1'b1, 3'd4, 1'b0);
    for (int c = 0; c < 5; c++) begin
      n_checks++;
      if (observed() !== exp_t) begin
        n_fail++;
        $display("FAIL bp_hold cycle %0d: got %h, want %h", c, observed(), exp_t);
      end
      n_checks++;
      if (bus.in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_in_ready cycle %0d: got %b, want 0", c, bus.in_ready);
      end
      tick();
    end
    bus.out_ready = 1'b1;
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_release_ready: got %b, want 1", bus.in_ready);
    end
    tick();  // 0x8D1 drains, slice 4 enters slot 0
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_release_drain: got %b, want 0", bus.out_valid);
    end
    send(3'd3, 1'b0);
    send(3'd2, 1'b0);
    send(3'd1, 1'b0);
    // 4 | 3<<3 | 2<<6 | 1<<9
    w.data = 12'h29C; w.count = 3'd4;
    exp_t = pack_exp(1'b1, w, 1'b0);
    n_checks++;
    if (observed() !== exp_t) begin
      n_fail++;
      $display("FAIL bp_next_word: got %h, want %h", observed(), exp_t);
    end
    // Stall with a single-slice word pending, then release: drain and reload
    // happen on the same edge, so out_valid never drops.
    bus.out_ready = 1'b0;
    drive(1'b1, 3'd5, 1'b1);
    tick();
    n_checks++;
    if (observed() !== exp_t) begin
      n_fail++;
      $display("FAIL bp_hold2: got %h, want %h", observed(), exp_t);
    end
    bus.out_ready = 1'b1;
    tick();
    w.data = 12'h005; w.count = 3'd1;
    exp_t = pack_exp(1'b1, w, 1'b1);
    n_checks++;
    if (observed() !== exp_t) begin
      n_fail++;
      $display("FAIL bp_handoff: got %h, want %h", observed(), exp_t);
    end
    drive(1'b0, '0, 1'b0);
    tick();
  endtask

  task automatic test_reset_midword();
    word_t w;
    logic [16:0] exp_t;
    bus.out_ready = 1'b1;
    send(3'd3, 1'b0);
    send(3'd3, 1'b0);
    // A closing slice is offered during reset; it must not be taken.
    rst = 1'b1;
    drive(1'b1, 3'd7, 1'b1);
    tick();
    exp_t = '0;
    n_checks++;
    if (observed() !== exp_t) begin
      n_fail++;
      $display("FAIL rst_during: got %h, want %h", observed(), exp_t);
    end
    rst = 1'b0;
    drive(1'b0, '0, 1'b0);
    tick();
    n_checks++;
    if (observed() !== exp_t) begin
      n_fail++;
      $display("FAIL rst_after: got %h, want %h", observed(), exp_t);
    end
    for (int i = 0; i < NS; i++) begin
      send(3'd1, 1'b0);
      if (i < NS - 1) begin
        n_checks++;
        if (bus.out_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL rst_early_valid beat %0d: got %b, want 0", i, bus.out_valid);
        end
      end
    end
    // 1 | 1<<3 | 1<<6 | 1<<9
    w.data = 12'h249; w.count = 3'd4;
    exp_t = pack_exp(1'b1, w, 1'b0);
    n_checks++;
    if (observed() !== exp_t) begin
      n_fail++;
      $display("FAIL rst_next_word: got %h, want %h", observed(), exp_t);
    end
    drive(1'b0, '0, 1'b0);
    tick();
  endtask

  task automatic test_streaming();
    word_t w;
    logic [16:0] exp_t;
    int words   = 0;
    int last_at = -1;
    int stalls  = 0;
    // 2 | 2<<3 | 2<<6 | 2<<9
    w.data = 12'h492; w.count = 3'd4;
    exp_t = pack_exp(1'b1, w, 1'b0);
    bus.out_ready = 1'b1;
    for (int c = 0; c < 3 * NS; c++) begin
      drive(1'b1, 3'd2, 1'b0);
      if (bus.in_ready !== 1'b1) stalls++;
      tick();
      if (bus.out_valid === 1'b1) begin
        words++;
        n_checks++;
        if (observed() !== exp_t) begin
          n_fail++;
          $display("FAIL stream_word at %0d: got %h, want %h", c, observed(), exp_t);
        end
        n_checks++;
        if ((last_at < 0 && c != NS - 1) || (last_at >= 0 && c - last_at != NS)) begin
          n_fail++;
          $display("FAIL stream_spacing at %0d: got prev %0d, want gap %0d", c, last_at, NS);
        end
        last_at = c;
      end
    end
    drive(1'b0, '0, 1'b0);
    tick();
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL stream_tail: got %b, want 0", bus.out_valid);
    end
    n_checks++;
    if (words != 3) begin
      n_fail++;
      $display("FAIL stream_words: got %0d, want 3", words);
    end
    n_checks++;
    if (stalls != 0) begin
      n_fail++;
      $display("FAIL stream_in_ready: got %0d stalled cycles, want 0", stalls);
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    rst           = 1'b1;
    test_reset();
    test_full_word();
    test_partial_and_single();
    test_backpressure();
    test_reset_midword();
    test_streaming();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_slice_packer
